// File: rtl/btb_pkg.sv
// Shared constants, entry field layout and controller state encoding
// for the branch target buffer write-port controller.
package btb_pkg;

  localparam int IDX_W   = 9;
  localparam int ENTRY_W = 25;
  localparam int DEPTH   = 512;

  // Entry layout: tag[24:18], strong[17], valid[16], target[15:0]
  localparam int TAG_MSB    = 24;
  localparam int TAG_LSB    = 18;
  localparam int STRONG_BIT = 17;
  localparam int VALID_BIT  = 16;
  localparam int TGT_MSB    = 15;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2,
    IDLE  = 2'd3
  } btb_flush_state_t;

  // All-zero entry: valid bit clear, so it never produces a hit.
  localparam logic [ENTRY_W-1:0] BTB_INVALID_ENTRY = '0;

endpackage

// File: rtl/btb_flush_ctrl_if.sv
// Update/write bus between the EX stage, the flush controller and the BTB array.
//
// Handshake: upd_wr is a fire-and-forget strobe with no ready signal. An update
// is accepted (and appears on mem_we/mem_widx/mem_wdata in the same cycle) only
// when the controller is idle; otherwise upd_dropped is raised in that same
// cycle and the update is lost, never queued.
interface btb_flush_ctrl_if #(
  parameter int IDX_W   = btb_pkg::IDX_W,
  parameter int ENTRY_W = btb_pkg::ENTRY_W
);

  logic               upd_wr;
  logic [IDX_W-1:0]   upd_idx;
  logic [ENTRY_W-1:0] upd_data;
  logic               upd_dropped;
  logic               mem_we;
  logic [IDX_W-1:0]   mem_widx;
  logic [ENTRY_W-1:0] mem_wdata;

  // Update source side; also observes the array write port.
  modport master (
    output upd_wr, upd_idx, upd_data,
    input  upd_dropped, mem_we, mem_widx, mem_wdata
  );

  // Controller side: owns the array write port.
  modport slave (
    input  upd_wr, upd_idx, upd_data,
    output upd_dropped, mem_we, mem_widx, mem_wdata
  );

endinterface

// File: rtl/btb_flush_ctrl.sv
// Owner of the BTB write port. Sweeps every entry to invalid after reset and
// on request, passes EX-stage updates through when idle, and holds lookups
// off until the array is known clean.
module btb_flush_ctrl
  import btb_pkg::*;
#(
  parameter int IDX_W   = btb_pkg::IDX_W,
  parameter int ENTRY_W = btb_pkg::ENTRY_W,
  parameter int DEPTH   = btb_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_req,
  btb_flush_ctrl_if.slave   bus,
  output logic              btb_en,
  output logic              flush_busy,
  output logic              flush_done,
  output logic [7:0]        flush_cnt,
  output btb_flush_state_t  dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  btb_flush_state_t state;
  logic [IDX_W-1:0] ptr;

  assign dbg_state = state;

  // FSM, sweep pointer and completed-sweep counter. The counter steps as the
  // last clear is written so the new count is visible alongside flush_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      ptr       <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        INIT: begin
          state <= FLUSH;
          ptr   <= '0;
        end
        FLUSH: begin
          ptr <= ptr + 1'b1;  // wraps to 0 after LAST_IDX by overflow
          if (ptr == LAST_IDX) begin
            state <= DONE;
            if (flush_cnt != 8'hFF) flush_cnt <= flush_cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        IDLE: begin
          // Requests outside IDLE are ignored: writes are blocked during a
          // sweep, so nothing valid can reappear before it completes.
          if (flush_req) begin
            state <= FLUSH;
            ptr   <= '0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Write-port mux and status decode from current state plus inputs.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_widx  = '0;
    bus.mem_wdata = ENTRY_W'(BTB_INVALID_ENTRY);
    btb_en        = 1'b0;
    flush_busy    = 1'b1;
    flush_done    = 1'b0;
    case (state)
      FLUSH: begin
        bus.mem_we   = 1'b1;
        bus.mem_widx = ptr;
      end
      DONE: begin
        flush_done = 1'b1;
      end
      IDLE: begin
        btb_en     = 1'b1;
        flush_busy = 1'b0;
        if (bus.upd_wr) begin
          bus.mem_we    = 1'b1;
          bus.mem_widx  = bus.upd_idx;
          bus.mem_wdata = bus.upd_data;
        end
      end
      default: ;
    endcase
    // Reset holds state at INIT, but a dropped update is not reported while
    // the block is still held in reset.
    bus.upd_dropped = bus.upd_wr && (state != IDLE) && rst_n;
  end

endmodule

// File: tb/tb_btb_flush_ctrl.sv
// Directed bench for btb_flush_ctrl: power-up sweep, idle pass-through table,
// flush/update collisions, ignored mid-sweep requests, mid-sweep reset, and
// sweep-counter saturation on a reduced-depth instance.
module tb_btb_flush_ctrl;
  import btb_pkg::*;

  logic clk;
  logic rst_n, rst_s;
  logic flush_req, flush_req_s;

  logic             btb_en, flush_busy, flush_done;
  logic [7:0]       flush_cnt;
  btb_flush_state_t dbg_state;

  logic             s_btb_en, s_flush_busy, s_flush_done;
  logic [7:0]       s_flush_cnt;
  btb_flush_state_t s_dbg_state;

  int checks = 0;
  int errors = 0;

  btb_flush_ctrl_if #(.IDX_W(9), .ENTRY_W(25)) bus ();
  btb_flush_ctrl_if #(.IDX_W(4), .ENTRY_W(25)) bus_s ();

  btb_flush_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_req  (flush_req),
    .bus        (bus.slave),
    .btb_en     (btb_en),
    .flush_busy (flush_busy),
    .flush_done (flush_done),
    .flush_cnt  (flush_cnt),
    .dbg_state  (dbg_state)
  );

  // Reduced-depth copy so counter saturation runs in a few thousand cycles.
  btb_flush_ctrl #(.IDX_W(4), .ENTRY_W(25), .DEPTH(16)) dut_s (
    .clk        (clk),
    .rst_n      (rst_s),
    .flush_req  (flush_req_s),
    .bus        (bus_s.slave),
    .btb_en     (s_btb_en),
    .flush_busy (s_flush_busy),
    .flush_done (s_flush_done),
    .flush_cnt  (s_flush_cnt),
    .dbg_state  (s_dbg_state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        upd_wr;
    logic [8:0]  idx;
    logic [24:0] data;
    logic        exp_we;
    logic [8:0]  exp_idx;
    logic [24:0] exp_data;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the active edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Runs n sweep cycles starting with the write of index 0. Optionally
  // injects an update (idx 0x050) at sweep index upd_at and a flush request
  // at sweep index req_at.
  task automatic run_sweep(input int n, input int upd_at, input int req_at);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      bus.upd_wr   = (i == upd_at);
      bus.upd_idx  = 9'h050;
      bus.upd_data = 25'h1FFFFFF;
      flush_req    = (i == req_at);
      settle();
      if (i == upd_at) begin
        check("sweep_upd_dropped", 32'(bus.upd_dropped), 32'd1);
        check("sweep_upd_widx", 32'(bus.mem_widx), 32'(i));
        check("sweep_upd_wdata", 32'(bus.mem_wdata), 32'd0);
      end
      if (bus.mem_we !== 1'b1 || bus.mem_widx !== 9'(i) || bus.mem_wdata !== 25'd0 ||
          btb_en !== 1'b0 || flush_busy !== 1'b1 || flush_done !== 1'b0 ||
          (i != upd_at && bus.upd_dropped !== 1'b0))
        errs++;
    end
    bus.upd_wr = 1'b0;
    flush_req  = 1'b0;
    check("sweep_bad_cycles", 32'(errs), 32'd0);
  endtask

  // DONE cycle followed by the first IDLE cycle.
  task automatic done_check(input int exp_cnt);
    tick();
    settle();
    check("done_pulse", 32'(flush_done), 32'd1);
    check("done_cnt", 32'(flush_cnt), 32'(exp_cnt));
    check("done_btb_en", 32'(btb_en), 32'd0);
    check("done_busy", 32'(flush_busy), 32'd1);
    check("done_no_write", 32'(bus.mem_we), 32'd0);
    check("done_state", 32'(dbg_state), 32'(DONE));
    tick();
    settle();
    check("idle_btb_en", 32'(btb_en), 32'd1);
    check("idle_busy", 32'(flush_busy), 32'd0);
    check("idle_done_low", 32'(flush_done), 32'd0);
    check("idle_state", 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    int pulses, cnt_errs, exp_c, extra_done;

    vecs[0] = '{1'b1, 9'h1A3, 25'h1FFFFFF, 1'b1, 9'h1A3, 25'h1FFFFFF};
    vecs[1] = '{1'b0, 9'h1FF, 25'h1234567, 1'b0, 9'h000, 25'h0000000};
    vecs[2] = '{1'b1, 9'h000, 25'h0050000, 1'b1, 9'h000, 25'h0050000};
    vecs[3] = '{1'b1, 9'h1FF, 25'h1F3ABCD, 1'b1, 9'h1FF, 25'h1F3ABCD};
    vecs[4] = '{1'b1, 9'h0AA, 25'h0000001, 1'b1, 9'h0AA, 25'h0000001};

    rst_n = 1'b1; rst_s = 1'b1;
    flush_req = 1'b0; flush_req_s = 1'b0;
    bus.upd_wr = 1'b1; bus.upd_idx = 9'h1A3; bus.upd_data = 25'h1FFFFFF;
    bus_s.upd_wr = 1'b0; bus_s.upd_idx = '0; bus_s.upd_data = '0;
    #3;
    rst_n = 1'b0; rst_s = 1'b0;

    // Reset values, with an update request pending
    repeat (3) tick();
    settle();
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_widx", 32'(bus.mem_widx), 32'd0);
    check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_btb_en", 32'(btb_en), 32'd0);
    check("rst_busy", 32'(flush_busy), 32'd1);
    check("rst_done", 32'(flush_done), 32'd0);
    check("rst_dropped", 32'(bus.upd_dropped), 32'd0);
    check("rst_cnt", 32'(flush_cnt), 32'd0);

    // Power-up: one INIT cycle, full sweep, DONE, then IDLE
    tick();
    rst_n = 1'b1;
    bus.upd_wr = 1'b0;
    settle();
    check("init_state", 32'(dbg_state), 32'(INIT));
    check("init_no_write", 32'(bus.mem_we), 32'd0);
    check("init_busy", 32'(flush_busy), 32'd1);
    check("init_btb_en", 32'(btb_en), 32'd0);
    run_sweep(512, -1, -1);
    done_check(1);

    // Idle pass-through table
    foreach (vecs[k]) begin
      tick();
      bus.upd_wr   = vecs[k].upd_wr;
      bus.upd_idx  = vecs[k].idx;
      bus.upd_data = vecs[k].data;
      settle();
      check("tbl_we", 32'(bus.mem_we), 32'(vecs[k].exp_we));
      check("tbl_widx", 32'(bus.mem_widx), 32'(vecs[k].exp_idx));
      check("tbl_wdata", 32'(bus.mem_wdata), 32'(vecs[k].exp_data));
      check("tbl_dropped", 32'(bus.upd_dropped), 32'd0);
    end
    bus.upd_wr = 1'b0;

    // Flush request and update together: update lands first, then the sweep.
    // Mid-sweep update at index 100 is dropped.
    tick();
    flush_req    = 1'b1;
    bus.upd_wr   = 1'b1;
    bus.upd_idx  = 9'h005;
    bus.upd_data = 25'h0012345;
    settle();
    check("coll_we", 32'(bus.mem_we), 32'd1);
    check("coll_widx", 32'(bus.mem_widx), 32'h005);
    check("coll_wdata", 32'(bus.mem_wdata), 32'h0012345);
    check("coll_dropped", 32'(bus.upd_dropped), 32'd0);
    run_sweep(512, 100, -1);
    done_check(2);

    // Request during the sweep at index 300 is ignored: no restart, one done pulse
    tick();
    flush_req = 1'b1;
    settle();
    check("req_idle_cycle", 32'(dbg_state), 32'(IDLE));
    run_sweep(512, -1, 300);
    done_check(3);
    extra_done = 0;
    repeat (4) begin
      tick();
      settle();
      if (flush_done === 1'b1 || flush_busy !== 1'b0) extra_done++;
    end
    check("no_restart", 32'(extra_done), 32'd0);

    // Reset asserted at sweep index 300
    tick();
    flush_req = 1'b1;
    settle();
    run_sweep(300, -1, -1);
    tick();
    rst_n = 1'b0;
    bus.upd_wr = 1'b1;
    #1;
    check("mid_rst_we", 32'(bus.mem_we), 32'd0);
    check("mid_rst_widx", 32'(bus.mem_widx), 32'd0);
    check("mid_rst_wdata", 32'(bus.mem_wdata), 32'd0);
    check("mid_rst_btb_en", 32'(btb_en), 32'd0);
    check("mid_rst_busy", 32'(flush_busy), 32'd1);
    check("mid_rst_done", 32'(flush_done), 32'd0);
    check("mid_rst_dropped", 32'(bus.upd_dropped), 32'd0);
    check("mid_rst_cnt", 32'(flush_cnt), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(INIT));
    settle();
    tick();
    tick();
    rst_n = 1'b1;
    bus.upd_wr = 1'b0;
    settle();
    check("re_init_state", 32'(dbg_state), 32'(INIT));
    check("re_init_cnt", 32'(flush_cnt), 32'd0);
    run_sweep(512, -1, -1);
    done_check(1);

    // Saturation: power-up sweep plus 256 back-to-back requests
    tick();
    rst_s = 1'b1;
    flush_req_s = 1'b1;
    pulses = 0;
    cnt_errs = 0;
    for (int c = 0; c < 8000; c++) begin
      settle();
      if (s_flush_done === 1'b1) begin
        pulses++;
        exp_c = (pulses > 255) ? 255 : pulses;
        if (s_flush_cnt !== 8'(exp_c)) cnt_errs++;
      end
      if (pulses == 257) break;
      tick();
    end
    flush_req_s = 1'b0;
    check("sat_pulses", 32'(pulses), 32'd257);
    check("sat_cnt_track", 32'(cnt_errs), 32'd0);
    check("sat_cnt_final", 32'(s_flush_cnt), 32'd255);
    tick();
    settle();
    check("sat_cnt_hold", 32'(s_flush_cnt), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_flush_ctrl.md
Name: btb_flush_ctrl

Overview:
Controller that owns the single write port of the 512-entry branch target buffer.
- Sequences a full invalidation sweep at power-up, because the BTB array cannot take an asynchronous reset.
- Sequences the same sweep on request, e.g. on a context switch or self-modifying-code event.
- Passes EX-stage allocate/evict/strength updates through to the array when no sweep is running.
- Gates BTB lookups off until the array is known clean.

Parameters:
IDX_W, 9, index width of the BTB array
ENTRY_W, 25, entry width: tag[24:18], strong[17], valid[16], target[15:0]
DEPTH, 512, number of entries; must equal 2**IDX_W

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
flush_req  in  1  one-cycle request to invalidate the whole BTB
upd_wr  in  1  EX-stage BTB update write request
upd_idx  in  IDX_W  index for the update write
upd_data  in  ENTRY_W  entry data for the update write
mem_we  out  1  write enable to the BTB array
mem_widx  out  IDX_W  write index to the BTB array
mem_wdata  out  ENTRY_W  write data to the BTB array
btb_en  out  1  lookup enable; hits must be qualified with this
flush_busy  out  1  high while a sweep is pending or in progress
flush_done  out  1  one-cycle pulse when a sweep completes
upd_dropped  out  1  an update was discarded this cycle because a sweep is active
flush_cnt  out  8  number of completed sweeps, saturating at 255

Behaviour:
- States: INIT, FLUSH, DONE, IDLE. Reset forces INIT, sweep pointer ptr=0 and flush_cnt=0.
- Values while rst_n is low: mem_we=0, mem_widx=0, mem_wdata=0, btb_en=0, flush_busy=1, flush_done=0, upd_dropped=0.
- INIT: lasts exactly one cycle; no write. Next state is FLUSH.
- FLUSH: every cycle drive mem_we=1, mem_widx=ptr, mem_wdata=0 (valid=0).
  - ptr increments by 1 each cycle.
  - In the cycle with ptr==DEPTH-1, the next state is DONE and ptr wraps to 0.
  - A sweep is exactly DEPTH write cycles, with indices 0..DEPTH-1 in order and no gaps.
- DONE: lasts one cycle; no write.
  - flush_done=1.
  - flush_cnt increments unless it is already 255.
  - Next state is IDLE.
- IDLE: btb_en=1 and flush_busy=0. The update path is combinational with zero latency: mem_we=upd_wr, mem_widx=upd_idx, mem_wdata=upd_data. When upd_wr=0, mem_widx and mem_wdata are driven to 0.
- btb_en is 0 in INIT, FLUSH and DONE. flush_busy is 1 in INIT, FLUSH and DONE.
- flush_req in IDLE: the next state is FLUSH with ptr=0.
- flush_req and upd_wr in the same IDLE cycle: the update is written in that cycle, then the sweep starts in the next cycle and clears it.
- flush_req in INIT, FLUSH or DONE: ignored. No restart or extension is needed, because all writes are blocked during a sweep, so the array cannot regain valid entries.
- upd_wr in any non-IDLE state: no array write occurs, and upd_dropped=1 combinationally in the same cycle. The update is not queued.
- Reset asserted mid-sweep: the block returns to INIT with ptr=0, and a full sweep restarts after release. flush_cnt is cleared.
- ptr is IDX_W bits wide; the wrap from DEPTH-1 to 0 is natural overflow.
- Registered elements: state, ptr and flush_cnt only. All other outputs are decoded from the current state plus inputs.

Decomposition:
- Package btb_pkg holds:
  - IDX_W, ENTRY_W and DEPTH;
  - the field positions TAG_MSB=24, TAG_LSB=18, STRONG_BIT=17, VALID_BIT=16 and TGT_MSB=15;
  - the state enum typedef btb_flush_state_t {INIT, FLUSH, DONE, IDLE};
  - the constant BTB_INVALID_ENTRY = '0.
- No sub-module is required. The sweep pointer and FSM sit in one module of about 150 lines.

Test Plan:
1. Release rst_n, then count cycles. Required: one INIT cycle, then 512 consecutive cycles with mem_we=1, mem_widx 0..511 and mem_wdata=0. Then one cycle with flush_done=1 and flush_cnt=1. btb_en rises on the following cycle, and flush_busy falls in the same cycle as btb_en rises.
2. In IDLE, apply upd_wr=1, upd_idx=0x1A3, upd_data=0x1FFFFFF. Required in the same cycle: mem_we=1, mem_widx=0x1A3, mem_wdata=0x1FFFFFF and upd_dropped=0.
3. In IDLE, apply flush_req and upd_wr (idx 0x005) together. Required: the 0x005 write happens that cycle. The next cycle writes idx 0 with data 0. Index 0x005 is later rewritten with 0. flush_done occurs 513 cycles after the request edge.
4. During FLUSH (ptr=100), apply upd_wr=1 with idx 0x050. Required: mem_widx=100, mem_wdata=0 and upd_dropped=1. No write to 0x050 appears in this sweep beyond its own clear.
5. Pulse flush_req at ptr=300. Required: the sweep completes at 511 with no restart, and exactly one flush_done pulse. Separately, assert rst_n low at ptr=300. Required: all outputs take their reset values immediately, and after release a fresh INIT plus 512-write sweep runs with flush_cnt=0 then 1.
6. Run 256 back-to-back flush requests. Required: flush_cnt saturates at 255 and stays at 255.
